// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encodings and a
// width helper for the iteration counter.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so the counter always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/parametric_RCA.sv
// Ripple-carry adder of parametric width: sum/cout = x + y + cin.
module parametric_RCA #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] x,
    input  logic [SIZE-1:0] y,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    logic [SIZE:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ w_carry[i];
        assign w_carry[i+1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
    end

    assign cout = w_carry[SIZE];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned SIZE x SIZE multiplier: one conditional add through the
// ripple-carry adder plus one right shift per clock, SIZE clocks per product.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);

    localparam int CNT_W = clog2(SIZE);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SIZE-1:0]    r_mcand;
    logic [2*SIZE-1:0]  r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*SIZE-1:0]  r_product;

    logic [SIZE-1:0]    w_hi;
    logic [SIZE-1:0]    w_lo;
    logic [SIZE-1:0]    w_y;
    logic [SIZE-1:0]    w_sum;
    logic               w_cout;
    logic [2*SIZE-1:0]  w_shifted;
    logic               w_last;
    logic               w_accept;

    assign w_hi = r_acc[2*SIZE-1:SIZE];
    assign w_lo = r_acc[SIZE-1:0];
    assign w_y  = w_lo[0] ? r_mcand : '0;

    parametric_RCA #(.SIZE(SIZE)) u_rca (
        .x    (w_hi),
        .y    (w_y),
        .cin  (1'b0),
        .cout (w_cout),
        .sum  (w_sum)
    );

    // The adder carry becomes the new MSB; dropping it corrupts large products.
    assign w_shifted = {w_cout, w_sum, w_lo[SIZE-1:1]};
    assign w_last    = (r_cnt == CNT_W'(SIZE - 1));
    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? CALC : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mcand <= a;
                r_acc   <= {{SIZE{1'b0}}, b};
                r_cnt   <= '0;
            end else if (r_state == CALC) begin
                r_acc <= w_shifted;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_product <= w_shifted;
                end
            end
        end
    end

    assign busy    = (r_state == CALC);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule
